// File: rtl/montgomery_seq_ctrl.sv
// Bit-serial 8-bit Montgomery multiplier C = A*B*2^-8 mod N; MONT_MODCHK_EN adds the even/small-modulus trap.
// Latency: done 10 cycles after an accepted start (2 on trapped modulus); no backpressure, start only sampled in IDLE.
module montgomery_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] n,
    output logic       busy,
    output logic       done,
    output logic [7:0] c,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

    state_t     state;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] n_q;
    logic [9:0] s_q;
    logic [2:0] cnt;

    logic [9:0] t;
    logic [9:0] u;
    logic [9:0] s_next;
    logic       mod_bad;

    // One radix-2 Montgomery step; a_q is shifted so bit 0 is always the current digit.
    always_comb begin
        t      = s_q + (a_q[0] ? {2'b00, b_q} : 10'd0);
        u      = t + (t[0] ? {2'b00, n_q} : 10'd0);
        s_next = {1'b0, u[9:1]};
    end

`ifdef MONT_MODCHK_EN
    always_comb begin
        mod_bad = ~n[0] | (n < 8'd3);
    end
`else
    always_comb begin
        mod_bad = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= 8'd0;
            b_q   <= 8'd0;
            n_q   <= 8'd0;
            s_q   <= 10'd0;
            cnt   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            c     <= 8'd0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        n_q <= n;
                        s_q <= 10'd0;
                        err <= 1'b0;
                        if (mod_bad) begin
                            // cnt=1 makes DONE wait one extra cycle before pulsing
                            cnt   <= 3'd1;
                            c     <= 8'd0;
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt   <= 3'd0;
                            busy  <= 1'b1;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    s_q <= s_next;
                    a_q <= {1'b0, a_q[7:1]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    c     <= (s_q >= {2'b00, n_q}) ? (s_q[7:0] - n_q) : s_q[7:0];
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    if (cnt != 3'd0) begin
                        cnt <= 3'd0;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_seq_ctrl.sv
// Directed-vector bench for montgomery_seq_ctrl: table of operands with hand-computed results plus
// sequences for back-to-back start, mid-operation reset and operand changes while busy.
module tb_montgomery_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic       busy;
    logic       done;
    logic [7:0] c;
    logic       err;

    int checks;
    int errors;

    montgomery_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .c     (c),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vn;
        bit         chk_c;
        logic [7:0] exp_c;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issues one start pulse and waits (bounded) for done. Latency counts edges after the accepting edge.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] in_n,
                          input bit scramble,
                          output logic [7:0] oc, output logic oerr, output int lat, output int bcnt);
        @(negedge clk);
        a = ia; b = ib; n = in_n; start = 1'b1;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        oc   = 8'hxx;
        oerr = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble && i == 1) begin
                a = 8'd12; b = 8'd3; n = 8'd7;
            end
            if (busy) bcnt++;
            if (done) begin
                lat  = i;
                oc   = c;
                oerr = err;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        repeat (2) @(negedge clk);
        check("c_held", int'(c), int'(oc));
    endtask

    logic [7:0] rc;
    logic       rerr;
    int         rlat;
    int         rbusy;
    int         seen;
    int         first_lat;
    int         second_lat;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;
        n      = 8'd0;

        vecs[0]  = '{8'd5,   8'd7,   8'd13,  1'b1, 8'd1,   1'b0, 10};
        vecs[1]  = '{8'd254, 8'd254, 8'd255, 1'b1, 8'd1,   1'b0, 10};
        vecs[2]  = '{8'd1,   8'd1,   8'd251, 1'b1, 8'd201, 1'b0, 10};
        vecs[3]  = '{8'd0,   8'd9,   8'd13,  1'b1, 8'd0,   1'b0, 10};
        vecs[4]  = '{8'd3,   8'd4,   8'd13,  1'b1, 8'd10,  1'b0, 10};
        vecs[5]  = '{8'd12,  8'd12,  8'd13,  1'b1, 8'd3,   1'b0, 10};
        vecs[6]  = '{8'd2,   8'd1,   8'd3,   1'b1, 8'd2,   1'b0, 10};
        vecs[7]  = '{8'd100, 8'd200, 8'd251, 1'b1, 8'd235, 1'b0, 10};
`ifdef MONT_MODCHK_EN
        vecs[8]  = '{8'd5,   8'd7,   8'd12,  1'b1, 8'd0,   1'b1, 2};
`else
        vecs[8]  = '{8'd5,   8'd7,   8'd12,  1'b0, 8'd0,   1'b0, 10};
`endif
        vecs[9]  = '{8'd1,   8'd1,   8'd13,  1'b1, 8'd3,   1'b0, 10};
        vecs[10] = '{8'd200, 8'd200, 8'd13,  1'b0, 8'd0,   1'b0, 10};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_c",    int'(c),    0);
        check("rst_err",  int'(err),  0);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            run_op(vecs[k].va, vecs[k].vb, vecs[k].vn, 1'b0, rc, rerr, rlat, rbusy);
            check($sformatf("v%0d_lat", k), rlat, vecs[k].exp_lat);
            check($sformatf("v%0d_err", k), int'(rerr), int'(vecs[k].exp_err));
            if (vecs[k].chk_c) check($sformatf("v%0d_c", k), int'(rc), int'(vecs[k].exp_c));
            check($sformatf("v%0d_busy_cycles", k), rbusy, (vecs[k].exp_lat == 10) ? 9 : 0);
        end

        // operands change while busy: latched values must win
        run_op(8'd5, 8'd7, 8'd13, 1'b1, rc, rerr, rlat, rbusy);
        check("scramble_c", int'(rc), 1);
        check("scramble_lat", rlat, 10);

        // start held high: second op takes operands present after the first done
        @(negedge clk);
        a = 8'd5; b = 8'd7; n = 8'd13; start = 1'b1;
        @(posedge clk);
        seen = 0; first_lat = -1; second_lat = -1;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (done) begin
                seen++;
                if (seen == 1) begin
                    first_lat = i;
                    check("b2b_c1", int'(c), 1);
                    a = 8'd3; b = 8'd4;
                end else begin
                    second_lat = i;
                    check("b2b_c2", int'(c), 10);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_lat1", first_lat, 10);
        check("b2b_lat2", second_lat, 21);
        repeat (2) @(negedge clk);
        check("b2b_no_third", int'(busy), 0);

        // reset mid-iteration aborts with no done pulse
        @(negedge clk);
        a = 8'd5; b = 8'd7; n = 8'd13; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_c",    int'(c),    0);
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        run_op(8'd5, 8'd7, 8'd13, 1'b0, rc, rerr, rlat, rbusy);
        check("after_abort_c", int'(rc), 1);
        check("after_abort_lat", rlat, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
